exec_wb_unit: RTL and testbench

- Execute/write-back stage directly downstream of the register-file read ports.
- Takes two operands (from BusA/BusB), an opcode and a destination index, and computes the result.
- Drives the register-file write port (we, dst, Din) one cycle after issue for single-cycle ops, or after an N-cycle iterative sequence for MUL.
- Provides valid/ready issue handshake so upstream decode can stall.

---
 rtl/exec_pkg.sv | 34 +++
 rtl/exec_wb_unit_alu_comb.sv | 40 ++++
 rtl/exec_wb_unit.sv | 169 ++++++++++++++++
 tb/tb_exec_wb_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared opcode and state encodings for the execute/write-back stage.
// EXEC_MUL_EN selects whether opcode MUL counts as a legal opcode.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } exec_state_e;

  // Highest opcode the ALU resolves in a single cycle.
  localparam logic [3:0] OP_LAST_SINGLE = 4'd9;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;
`else
  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;
`endif

endpackage

// File: rtl/exec_wb_unit_alu_comb.sv
// Combinational single-cycle ALU for exec_wb_unit; any opcode it does not
// resolve itself (including MUL) is reported as illegal.
module alu_comb
  import exec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_result,
  output logic         o_illegal
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] w_shamt;

  assign w_shamt = i_b[SW-1:0];

  // Result select; upper bits of the shift operand are ignored.
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLL:  o_result = i_a << w_shamt;
      OP_SRL:  o_result = i_a >> w_shamt;
      OP_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
      OP_SLT:  o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: o_result = {{(N-1){1'b0}}, (i_a < i_b)};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_wb_unit.sv
// Execute/write-back stage feeding the register-file write port.
// Define EXEC_MUL_EN to build in the iterative N-cycle shift-add multiplier.
module exec_wb_unit
  import exec_pkg::*;
#(
  parameter int N       = 32,
  parameter int W       = 32,
  parameter int R0_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [N-1:0]         in_a,
  input  logic [N-1:0]         in_b,
  input  logic [$clog2(W)-1:0] in_dst,
  output logic                 wb_we,
  output logic [$clog2(W)-1:0] wb_dst,
  output logic [N-1:0]         wb_data,
  output logic                 busy,
  output logic                 err
);

  localparam int DW = $clog2(W);

  logic [N-1:0]  w_alu_result;
  logic          w_alu_illegal;
  logic          w_accept;
  logic          w_is_mul;
  logic          w_illegal;
  logic          w_mul_fire;
  logic [N-1:0]  w_mul_product;
  logic [DW-1:0] w_mul_dst;
  logic          w_wb_fire;
  logic [DW-1:0] w_wb_dst;
  logic [N-1:0]  w_wb_data;
  logic          r_wb_we;
  logic [DW-1:0] r_wb_dst;
  logic [N-1:0]  r_wb_data;
  logic          r_err;

  function automatic logic dst_writable(input logic [DW-1:0] d);
    return !((R0_ZERO != 0) && (d == '0));
  endfunction

  alu_comb #(.N(N)) u_alu (
    .i_op      (in_op),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_illegal = w_accept && w_alu_illegal && !w_is_mul;

`ifdef EXEC_MUL_EN
  localparam int            SW       = $clog2(N);
  localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

  exec_state_e   r_state;
  exec_state_e   w_state_next;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplier;
  logic [N-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic [DW-1:0] r_mul_dst;
  logic [N-1:0]  w_acc_step;

  assign w_is_mul      = (in_op == OP_MUL);
  assign in_ready      = (r_state == IDLE);
  assign busy          = (r_state == MUL);
  assign w_acc_step    = r_acc + (r_mplier[0] ? r_mcand : '0);
  // The last step's sum goes straight to write-back, so the pulse shows during DONE.
  assign w_mul_fire    = (r_state == MUL) && (r_cnt == CNT_LAST);
  assign w_mul_product = w_acc_step;
  assign w_mul_dst     = r_mul_dst;

  // Multiplier sequencing: IDLE -> MUL (N steps) -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) w_state_next = MUL;
        else                      w_state_next = IDLE;
      end
      MUL: begin
        if (r_cnt == CNT_LAST) w_state_next = DONE;
        else                   w_state_next = MUL;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Shift-add datapath: multiplier consumed LSB first, multiplicand shifted left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_mul_dst <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand   <= in_a;
      r_mplier  <= in_b;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_mul_dst <= in_dst;
    end else if (r_state == MUL) begin
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_acc     <= w_acc_step;
      r_cnt     <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul      = 1'b0;
  assign in_ready      = 1'b1;
  assign busy          = 1'b0;
  assign w_mul_fire    = 1'b0;
  assign w_mul_product = '0;
  assign w_mul_dst     = '0;
`endif

  // Write-back source select; MUL completion and a new issue never coincide.
  always_comb begin
    w_wb_fire = 1'b0;
    w_wb_dst  = in_dst;
    w_wb_data = w_alu_result;
    if (w_mul_fire) begin
      w_wb_fire = dst_writable(w_mul_dst);
      w_wb_dst  = w_mul_dst;
      w_wb_data = w_mul_product;
    end else if (w_accept && !w_is_mul && !w_alu_illegal) begin
      w_wb_fire = dst_writable(in_dst);
    end else begin
      w_wb_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wb_we <= w_wb_fire;
      if (w_wb_fire) begin
        r_wb_dst  <= w_wb_dst;
        r_wb_data <= w_wb_data;
      end
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign wb_we   = r_wb_we;
  assign wb_dst  = r_wb_dst;
  assign wb_data = r_wb_data;
  assign err     = r_err;

endmodule

// File: tb/tb_exec_wb_unit.sv
// Scoreboard bench for exec_wb_unit: directed cases plus random ops against a
// plain-arithmetic reference model; honours EXEC_MUL_EN like the design.
module tb_exec_wb_unit;
  import exec_pkg::*;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int DW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [DW-1:0] in_dst;
  logic          wb_we;
  logic [DW-1:0] wb_dst;
  logic [N-1:0]  wb_data;
  logic          busy;
  logic          err;

  exec_wb_unit #(.N(N), .W(W), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dst;
    logic [N-1:0]  data;
    int            at;
  } wb_t;

  wb_t  exp_q[$];
  wb_t  mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   exp_err = 1'b0;
  logic rst_q = 1'b1;
  logic [DW-1:0] last_dst  = '0;
  logic [N-1:0]  last_data = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: what the register file should receive for one op.
  function automatic void model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                output bit legal, output bit is_mul, output logic [N-1:0] r);
    int unsigned sh;
    logic [2*N-1:0] p;
    sh     = b % N;
    legal  = 1'b1;
    is_mul = 1'b0;
    r      = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = $unsigned($signed(a) >>> sh);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef EXEC_MUL_EN
      4'd10: begin
        p      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r      = p[N-1:0];
        is_mul = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  // Holds in_valid until accepted; returns at the falling edge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [DW-1:0] dst, input bit push);
    int n = 0;
    bit legal, is_mul;
    logic [N-1:0] r;
    wb_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL issue_timeout: in_ready still %0b after %0d cycles, expected 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, legal, is_mul, r);
    if (push && legal && dst != '0) begin
      e.dst = dst; e.data = r; e.at = cyc + 1 + (is_mul ? N : 0);
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!legal) exp_err = 1'b1;
    chk("err_flag", {31'd0, err}, {31'd0, exp_err});
  endtask

  // Monitor: every write-back pulse pops one expectation; outputs hold otherwise.
  always @(negedge clk) begin
    if (rst_q) begin
      last_dst  <= '0;
      last_data <= '0;
    end else if (wb_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_wb: got dst %0d data 0x%08h, expected no write-back (cycle %0d)",
                 wb_dst, wb_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_dst", {27'd0, wb_dst}, {27'd0, mon_e.dst});
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_cycle", 32'(cyc), 32'(mon_e.at));
      end
      last_dst  <= wb_dst;
      last_data <= wb_data;
    end else begin
      chk("hold_dst", {27'd0, wb_dst}, {27'd0, last_dst});
      chk("hold_data", wb_data, last_data);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [3:0] op;
    logic [N-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_dst = '0;
    repeat (2) @(negedge clk);
    chk("rst_wb_we",    {31'd0, wb_we},    32'd0);
    chk("rst_wb_data",  wb_data,           32'd0);
    chk("rst_wb_dst",   {27'd0, wb_dst},   32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 1'b1);
    issue(OP_SRA,  32'h8000_0000, 32'h0000_0024, 5'd4, 1'b1);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1'b1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1);
    issue(OP_ADD,  32'h0000_0005, 32'h0000_0006, 5'd0, 1'b1);
    issue(4'd12,   32'h1234_5678, 32'h0000_0001, 5'd8, 1'b1);
    chk("illegal_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);

`ifdef EXEC_MUL_EN
    issue(OP_MUL, 32'd1234, 32'd5678, 5'd7, 1'b1);
    t0 = cyc;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd7; in_b = 32'd8; in_dst = 5'd9;
    for (int k = 0; k < N; k++) begin
      chk("mul_busy",  {31'd0, busy},     32'd1);
      chk("mul_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("done_busy",  {31'd0, busy},     32'd0);
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    chk("done_wb_we", {31'd0, wb_we},    32'd1);
    issue(OP_ADD, 32'd7, 32'd8, 5'd9, 1'b1);
    chk("held_accept_cycle", 32'(cyc), 32'(t0 + N + 2));

    issue(OP_MUL, 32'hDEAD_BEEF, 32'h0000_1001, 5'd10, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},     32'd0);
    chk("abort_wb_we", {31'd0, wb_we},    32'd0);
    chk("abort_err",   {31'd0, err},      32'd0);
    repeat (N + 8) @(negedge clk);
`else
    issue(4'd10, 32'd3, 32'd4, 5'd11, 1'b1);
    chk("op10_err", {31'd0, err}, 32'd1);
    chk("op10_ready", {31'd0, in_ready}, 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
      else                           op = 4'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(op, a, b, 5'($urandom_range(0, W - 1)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (N + 5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
